mmu_feeder: RTL and testbench



---
 rtl/tpu_pkg.sv | 19 +
 rtl/mmu_feeder_skew_line.sv | 35 +++
 rtl/mmu_feeder.sv | 175 +++++++++++++++++
 tb/tb_mmu_feeder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default dimensions for the matrix unit and its feeder.
package tpu_pkg;

    // Default array geometry, shared with mmu_array.
    localparam int unsigned N_DEFAULT    = 4;
    localparam int unsigned DW_DEFAULT   = 8;
    localparam int unsigned KMAX_DEFAULT = 256;

    // Feeder tile sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    // One activation or weight element at the default width.
    typedef logic [DW_DEFAULT-1:0] elem_t;

endpackage

// File: rtl/mmu_feeder_skew_line.sv
// Registered delay line of D stages carrying one data element plus a valid tag.
module skew_line #(
    parameter int unsigned D  = 1,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_valid,
    input  logic [DW-1:0] shift_data,
    output logic          tap_valid,
    output logic [DW-1:0] tap_data
);

    logic [D-1:0]         vld_q;
    logic [D-1:0][DW-1:0] dat_q;

    // Shift every cycle; stage 0 takes the injected entry, stage D-1 is the tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= shift_valid;
            dat_q[0] <= shift_data;
            for (int unsigned i = 1; i < D; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign tap_valid = vld_q[D-1];
    assign tap_data  = dat_q[D-1];

endmodule

// File: rtl/mmu_feeder.sv
// Skewing front-end streamer for the systolic matrix unit: frames a tile of
// K unskewed steps, delays lane r by r cycles and flushes the skew afterwards.
module mmu_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned N    = N_DEFAULT,
    parameter int unsigned DW   = DW_DEFAULT,
    parameter int unsigned KMAX = KMAX_DEFAULT,
    parameter int unsigned CW   = $clog2(KMAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [CW-1:0]        k_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N-1:0][DW-1:0] act_vec_i,
    input  logic [N-1:0][DW-1:0] wgt_vec_i,
    output logic                 valid_o,
    output logic [N-1:0][DW-1:0] activation_rows,
    output logic [N-1:0][DW-1:0] weight_columns
);

    // Drain counter spans 0..N-2; keep at least one bit for small arrays.
    localparam int unsigned DCW        = (N > 2) ? $clog2(N - 1) : 1;
    localparam int unsigned DRAIN_LAST = (N > 1) ? N - 2 : 0;

    feeder_state_e state_q, state_d;

    logic [CW-1:0]  remaining_q, remaining_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           in_ready_d, busy_d, done_d;

    logic                 accept;
    logic                 last_accept;
    logic                 drain_end;
    logic                 tile_start;
    logic                 empty_start;
    logic [CW-1:0]        k_eff;
    logic                 inj_valid;
    logic [N-1:0][DW-1:0] inj_act;
    logic [N-1:0][DW-1:0] inj_wgt;
    logic [N-1:0]         act_tap_valid;
    logic [N-1:0]         wgt_tap_valid;

    // Handshake and tile-boundary decode shared by next-state and output logic.
    always_comb begin
        k_eff       = (k_len_i > CW'(KMAX)) ? CW'(KMAX) : k_len_i;
        accept      = in_valid_i & in_ready_o;
        last_accept = accept && (remaining_q == CW'(1));
        drain_end   = (state_q == DRAIN) && (drain_cnt_q == DCW'(DRAIN_LAST));
        tile_start  = (state_q == IDLE) && start_i && (k_len_i != '0);
        empty_start = (state_q == IDLE) && start_i && (k_len_i == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a single-lane array skips DRAIN entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tile_start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_accept) begin
                    state_d = (N > 1) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and counter next values, all taken from the upcoming state.
    always_comb begin
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        drain_cnt_d = drain_cnt_q;

        in_ready_d = (state_d == STREAM);
        busy_d     = (state_d == STREAM) || (state_d == DRAIN);

        if (empty_start || drain_end) begin
            done_d = 1'b1;
        end
        if ((N == 1) && (state_q == STREAM) && last_accept) begin
            done_d = 1'b1;
        end

        if (tile_start) begin
            remaining_d = k_eff;
        end else if (accept) begin
            remaining_d = remaining_q - CW'(1);
        end

        if ((state_q == STREAM) && (state_d == DRAIN)) begin
            drain_cnt_d = '0;
        end else if (state_q == DRAIN) begin
            drain_cnt_d = drain_cnt_q + DCW'(1);
        end
    end

    // Registered control outputs and tile counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            remaining_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            in_ready_o  <= in_ready_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            remaining_q <= remaining_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Stage-0 injection: accepted vectors, or zero bubbles tagged invalid.
    always_comb begin
        inj_valid = accept;
        inj_act   = accept ? act_vec_i : '0;
        inj_wgt   = accept ? wgt_vec_i : '0;
    end

    // One delay line per activation row and weight column, depth lane+1.
    for (genvar r = 0; r < int'(N); r++) begin : g_lane
        skew_line #(
            .D  (r + 1),
            .DW (DW)
        ) u_act_line (
            .clk         (clk),
            .rst         (rst),
            .shift_valid (inj_valid),
            .shift_data  (inj_act[r]),
            .tap_valid   (act_tap_valid[r]),
            .tap_data    (activation_rows[r])
        );

        skew_line #(
            .D  (r + 1),
            .DW (DW)
        ) u_wgt_line (
            .clk         (clk),
            .rst         (rst),
            .shift_valid (inj_valid),
            .shift_data  (inj_wgt[r]),
            .tap_valid   (wgt_tap_valid[r]),
            .tap_data    (weight_columns[r])
        );
    end

    // Array valid is high whenever any lane is presenting a real element.
    assign valid_o = (|act_tap_valid) | (|wgt_tap_valid);

endmodule

// File: tb/tb_mmu_feeder.sv
// Randomised scoreboard bench for mmu_feeder with per-lane expectation queues.
module tb_mmu_feeder;
    import tpu_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned KMAX = 256;
    localparam int unsigned CW   = $clog2(KMAX + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start_i = 1'b0;
    logic [CW-1:0]        k_len_i = '0;
    logic                 busy_o;
    logic                 done_o;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic [N-1:0][DW-1:0] act_vec_i = '0;
    logic [N-1:0][DW-1:0] wgt_vec_i = '0;
    logic                 valid_o;
    logic [N-1:0][DW-1:0] activation_rows;
    logic [N-1:0][DW-1:0] weight_columns;

    mmu_feeder #(
        .N    (N),
        .DW   (DW),
        .KMAX (KMAX),
        .CW   (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .k_len_i         (k_len_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .act_vec_i       (act_vec_i),
        .wgt_vec_i       (wgt_vec_i),
        .valid_o         (valid_o),
        .activation_rows (activation_rows),
        .weight_columns  (weight_columns)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [DW-1:0] a;
        logic [DW-1:0] w;
    } lane_ent_t;

    lane_ent_t lane_q[N][$];
    int        done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en    = 1'b0;
    bit exp_ready = 1'b0;
    bit exp_busy  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: each cycle, pop whatever the model says is due now and compare.
    always @(negedge clk) begin
        logic          any_v;
        logic          exp_d;
        logic [DW-1:0] ea;
        logic [DW-1:0] ew;
        if (mon_en) begin
            any_v = 1'b0;
            for (int r = 0; r < int'(N); r++) begin
                ea = '0;
                ew = '0;
                while (lane_q[r].size() > 0 && lane_q[r][0].cyc < cyc) begin
                    chk($sformatf("stale_lane%0d", r), 32'(lane_q[r][0].cyc), 32'(cyc));
                    void'(lane_q[r].pop_front());
                end
                if (lane_q[r].size() > 0 && lane_q[r][0].cyc == cyc) begin
                    ea    = lane_q[r][0].a;
                    ew    = lane_q[r][0].w;
                    any_v = 1'b1;
                    void'(lane_q[r].pop_front());
                end
                chk($sformatf("act_row%0d", r), 32'(activation_rows[r]), 32'(ea));
                chk($sformatf("wgt_col%0d", r), 32'(weight_columns[r]), 32'(ew));
            end
            chk("valid_o", 32'(valid_o), 32'(any_v));

            exp_d = 1'b0;
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                chk("done_missed", 32'(done_q[0]), 32'(cyc));
                void'(done_q.pop_front());
            end
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                exp_d = 1'b1;
                void'(done_q.pop_front());
            end
            chk("done_o", 32'(done_o), 32'(exp_d));
            chk("in_ready_o", 32'(in_ready_o), 32'(exp_ready));
            chk("busy_o", 32'(busy_o), 32'(exp_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vectors();
        for (int r = 0; r < int'(N); r++) begin
            act_vec_i[r] = DW'($urandom);
            wgt_vec_i[r] = DW'($urandom);
        end
    endtask

    // Idle cycle with random, ignored handshake noise.
    task automatic idle_cycle();
        exp_ready  = 1'b0;
        exp_busy   = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'($urandom_range(1));
        rand_vectors();
        tick();
    endtask

    // One tile: mode 0 random data, 1 lane-indexed data, 2 step-indexed data.
    task automatic run_tile(input int kraw, input int mode, input int bub_pct,
                            input bit one_bubble, input bit abort);
        int keff;
        int acc;
        bit bubbled;
        bit v;
        keff = (kraw > int'(KMAX)) ? int'(KMAX) : kraw;

        exp_ready  = 1'b0;
        exp_busy   = 1'b0;
        start_i    = 1'b1;
        k_len_i    = CW'(kraw);
        in_valid_i = 1'($urandom_range(1));
        rand_vectors();
        if (keff == 0) begin
            done_q.push_back(cyc + 1);
            tick();
            start_i    = 1'b0;
            in_valid_i = 1'b0;
            return;
        end
        tick();

        acc     = 0;
        bubbled = 1'b0;
        while (acc < keff) begin
            exp_ready = 1'b1;
            exp_busy  = 1'b1;
            start_i   = 1'($urandom_range(1));
            k_len_i   = CW'($urandom);
            v = ($urandom_range(99) >= bub_pct);
            if (one_bubble && acc == 1 && !bubbled) begin
                v       = 1'b0;
                bubbled = 1'b1;
            end
            rand_vectors();
            if (v && mode == 1) begin
                for (int r = 0; r < int'(N); r++) begin
                    act_vec_i[r] = DW'(r + 1);
                    wgt_vec_i[r] = DW'(r + 5);
                end
            end else if (v && mode == 2) begin
                for (int r = 0; r < int'(N); r++) begin
                    act_vec_i[r] = DW'(acc + 1);
                    wgt_vec_i[r] = DW'(10 + acc);
                end
            end
            in_valid_i = v;
            if (v) begin
                for (int r = 0; r < int'(N); r++) begin
                    lane_ent_t e;
                    e.cyc = cyc + 1 + r;
                    e.a   = act_vec_i[r];
                    e.w   = wgt_vec_i[r];
                    lane_q[r].push_back(e);
                end
                acc++;
                if (acc == keff) done_q.push_back(cyc + int'(N));
            end
            tick();
        end

        for (int d = 0; d < int'(N) - 1; d++) begin
            exp_ready  = 1'b0;
            exp_busy   = 1'b1;
            start_i    = 1'($urandom_range(1));
            k_len_i    = CW'($urandom);
            in_valid_i = 1'($urandom_range(1));
            rand_vectors();
            if (abort && d == 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int r = 0; r < int'(N); r++) lane_q[r].delete();
                done_q.delete();
                exp_busy   = 1'b0;
                start_i    = 1'b0;
                in_valid_i = 1'b0;
                return;
            end
            tick();
        end
        exp_ready  = 1'b0;
        exp_busy   = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
    endtask

    initial begin
        int left;
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        idle_cycle();
        idle_cycle();

        run_tile(1, 1, 0, 1'b0, 1'b0);
        run_tile(4, 2, 0, 1'b0, 1'b0);
        run_tile(2, 0, 0, 1'b1, 1'b0);
        run_tile(0, 0, 0, 1'b0, 1'b0);
        idle_cycle();
        run_tile(3, 0, 0, 1'b0, 1'b1);
        idle_cycle();
        run_tile(1, 1, 0, 1'b0, 1'b0);
        run_tile(511, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(2);
            for (int g = 0; g < gap; g++) idle_cycle();
            run_tile($urandom_range(8), 0, $urandom_range(40), 1'b0, 1'b0);
        end

        for (int i = 0; i < int'(N) + 2; i++) idle_cycle();
        @(negedge clk);
        #1;
        left = done_q.size();
        for (int r = 0; r < int'(N); r++) left += lane_q[r].size();
        chk("leftover_expectations", 32'(left), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
